// File: rtl/dwt_feature_serializer.sv
// Double-buffered feature-frame serializer: first word 1 cycle after capture; holds word while m_ready low.
// A frame is dropped (and counted) only when both buffers are full; FEAT_CHECKSUM_EN appends an XOR word.
module dwt_feature_serializer #(
    parameter int DATA_W = 32,
    parameter int N_FEAT = 20,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dwt_valid,
    input  logic [N_FEAT*DATA_W-1:0] dwt_features,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [4:0]               m_idx,
    output logic                     m_last,
    output logic                     busy,
    output logic                     overrun,
    output logic [CNT_W-1:0]         drop_cnt
);

`ifdef FEAT_CHECKSUM_EN
    localparam int NWORDS = N_FEAT + 1;
`else
    localparam int NWORDS = N_FEAT;
`endif
    localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DATA_W-1:0]  r_shadow  [NWORDS];
    logic [DATA_W-1:0]  r_pending [NWORDS];
    logic [DATA_W-1:0]  w_words   [NWORDS];
    logic               r_pend_full;
    logic [4:0]         r_idx;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               w_capture;
    logic               w_xfer;
    logic               w_last_xfer;

    for (genvar k = 0; k < N_FEAT; k++) begin : g_words
        assign w_words[k] = dwt_features[k*DATA_W +: DATA_W];
    end

`ifdef FEAT_CHECKSUM_EN
    // Checksum is formed at capture so it travels with whichever buffer holds the frame.
    logic [DATA_W-1:0] w_sum;
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N_FEAT; k++) begin
            w_sum = w_sum ^ dwt_features[k*DATA_W +: DATA_W];
        end
    end
    assign w_words[N_FEAT] = w_sum;
`endif

    assign w_capture   = en && dwt_valid;
    assign w_xfer      = m_valid && m_ready;
    assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_capture) w_next_state = SEND;
            SEND: if (w_last_xfer && !w_capture && !r_pend_full) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shadow    <= '{default: '0};
            r_pending   <= '{default: '0};
            r_pend_full <= 1'b0;
            r_idx       <= '0;
            r_overrun   <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                if (w_capture) begin
                    r_shadow <= w_words;
                    r_idx    <= '0;
                end
            end else if (w_last_xfer) begin
                // End of frame: next frame starts on the following cycle, no bubble.
                r_idx <= '0;
                if (r_pend_full) begin
                    r_shadow <= r_pending;
                    if (w_capture) r_pending <= w_words;
                    else           r_pend_full <= 1'b0;
                end else if (w_capture) begin
                    r_shadow <= w_words;
                end
            end else begin
                if (w_xfer) r_idx <= r_idx + 5'd1;
                if (w_capture) begin
                    if (!r_pend_full) begin
                        r_pending   <= w_words;
                        r_pend_full <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign m_valid  = (r_state == SEND);
    assign m_data   = m_valid ? r_shadow[r_idx] : '0;
    assign m_idx    = r_idx;
    assign m_last   = m_valid && (r_idx == LAST_IDX);
    assign busy     = m_valid || r_pend_full;
    assign overrun  = r_overrun;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dwt_feature_serializer.sv
// Scoreboarded bench for dwt_feature_serializer; stimulus pushes expected words, a negedge monitor pops them.
module tb_dwt_feature_serializer;
    localparam int DW = 32;
    localparam int NF = 20;
`ifdef FEAT_CHECKSUM_EN
    localparam int NW = NF + 1;
`else
    localparam int NW = NF;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           dwt_valid = 1'b0;
    logic [NF*DW-1:0] dwt_features = '0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [DW-1:0]  m_data;
    logic [4:0]     m_idx;
    logic           m_last;
    logic           busy;
    logic           overrun;
    logic [7:0]     drop_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   xfer_cnt = 0;
    int   run_len = 0;
    int   max_run = 0;
    bit   hold = 0;
    logic [37:0] held;

    dwt_feature_serializer #(.DATA_W(DW), .N_FEAT(NF), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .dwt_valid(dwt_valid), .dwt_features(dwt_features),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
        .busy(busy), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: inputs change just after posedge, so a negedge sample sees the coming edge's transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold    = 0;
            run_len = 0;
        end else begin
            if (hold) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_stable", 64'({m_data, m_idx, m_last}), 64'(held));
            end
            if (m_valid) run_len++;
            else         run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (m_valid && m_ready) begin
                xfer_cnt++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_word: got idx %0d data %h expected no word", m_idx, m_data);
                end else begin
                    e = q.pop_front();
                    check("word", 64'({m_data, m_idx, m_last}), 64'(e));
                end
            end
            hold = m_valid && !m_ready;
            held = {m_data, m_idx, m_last};
        end
    end

    function automatic logic [NF*DW-1:0] ramp(input int base);
        logic [NF*DW-1:0] v;
        for (int k = 0; k < NF; k++) v[k*DW +: DW] = 32'(base + k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle capture pulse; when keep is set the frame's words are queued as expected output.
    task automatic pulse(input logic [NF*DW-1:0] vec, input bit keep);
        logic [31:0] w;
        logic [31:0] cs;
        cs = '0;
        if (keep) begin
            for (int k = 0; k < NF; k++) begin
                w  = vec[k*DW +: DW];
                cs = cs ^ w;
                q.push_back('{d: w, i: 5'(k), l: (k == NW - 1)});
            end
`ifdef FEAT_CHECKSUM_EN
            q.push_back('{d: cs, i: 5'(NF), l: 1'b1});
`endif
        end
        dwt_features = vec;
        dwt_valid    = 1'b1;
        tick();
        dwt_valid    = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((q.size() != 0 || m_valid || busy) && c < 1000) begin
            tick();
            c++;
        end
        check("drain_done", 64'(q.size() == 0 && !m_valid && !busy), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int x0;
        logic [NF*DW-1:0] v6;
        repeat (3) tick();
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_outs", 64'({m_data, m_idx, m_last}), 64'd0);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // 1: single frame, full throughput
        m_ready = 1'b1;
        max_run = 0;
        x0 = xfer_cnt;
        check("t1_pre_valid", 64'(m_valid), 64'd0);
        pulse(ramp(100), 1);
        check("t1_latency", 64'({m_valid, m_idx}), 64'({1'b1, 5'd0}));
        wait_drain();
        check("t1_xfers", 64'(xfer_cnt - x0), 64'(NW));
        check("t1_run", 64'(max_run), 64'(NW));

        // 2: backpressure pattern 1,0,0,1
        x0 = xfer_cnt;
        pulse(ramp(200), 1);
        for (int c = 0; c < 400 && (xfer_cnt - x0) < NW; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        m_ready = 1'b1;
        wait_drain();
        check("t2_xfers", 64'(xfer_cnt - x0), 64'(NW));

        // 3: back-to-back frames, no bubble
        max_run = 0;
        x0 = xfer_cnt;
        pulse(ramp(300), 1);
        repeat (4) tick();
        pulse(ramp(400), 1);
        wait_drain();
        check("t3_run", 64'(max_run), 64'(2 * NW));
        check("t3_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t3_overrun", 64'(overrun), 64'd0);

        // 4: overrun while stalled
        m_ready = 1'b0;
        x0 = xfer_cnt;
        pulse(ramp(500), 1);
        repeat (2) tick();
        pulse(ramp(600), 1);
        repeat (2) tick();
        pulse(ramp(700), 0);
        tick();
        check("t4_overrun", 64'(overrun), 64'd1);
        check("t4_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_no_xfer", 64'(xfer_cnt - x0), 64'd0);
        m_ready = 1'b1;
        wait_drain();
        check("t4_xfers", 64'(xfer_cnt - x0), 64'(2 * NW));

        // 5: reset mid-frame, then en low
        pulse(ramp(800), 1);
        for (int c = 0; c < 100 && m_idx != 5'd7; c++) tick();
        check("t5_reached_idx7", 64'(m_idx), 64'd7);
        rst = 1'b1;
        tick();
        q.delete();
        check("t5_rst_outs", 64'({m_valid, m_data, m_idx, m_last}), 64'd0);
        check("t5_rst_flags", 64'({busy, overrun, drop_cnt}), 64'd0);
        rst = 1'b0;
        en  = 1'b0;
        for (int p = 0; p < 3; p++) begin
            dwt_features = ramp(900 + p);
            dwt_valid = 1'b1;
            tick();
            dwt_valid = 1'b0;
            tick();
            check("t5_en_low", 64'({busy, m_valid}), 64'd0);
        end
        en = 1'b1;

`ifdef FEAT_CHECKSUM_EN
        // 6: checksum word, hand-computed 0xF0 ^ 0x0F
        v6 = '0;
        v6[3*DW +: DW] = 32'h0000_00F0;
        v6[4*DW +: DW] = 32'h0000_000F;
        for (int k = 0; k < NF; k++) q.push_back('{d: v6[k*DW +: DW], i: 5'(k), l: 1'b0});
        q.push_back('{d: 32'h0000_00FF, i: 5'd20, l: 1'b1});
        pulse(v6, 0);
        wait_drain();
`else
        v6 = ramp(1000);
        pulse(v6, 1);
        wait_drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
